// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduce_arbiter / reduce_sum slice.
// Holds the scheduler state enum, the id-width helper and default sizes.
package reduce_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 2048;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT,
        RESULT,
        CLEAR
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i.
// Ports: req_i (request vector), ptr_i (start index),
//        gnt_oh_o (one-hot grant), idx_o (encoded grant), any_o (any request).
module rr_arbiter
    import reduce_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;
    logic          found;

    always_comb begin
        gnt_oh_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        sum      = '0;
        k        = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate index (ptr + i) mod N without a divider.
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k = sum[IW-1:0];
            if (!found && req_i[k]) begin
                found       = 1'b1;
                gnt_oh_o[k] = 1'b1;
                idx_o       = k;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/reduce_arbiter.sv
// Frame scheduler sharing one reduce_sum engine among N_REQ requesters.
// Ports: clk/rst; req_valid/req_data/req_ready (requester streams);
//        eng_in_data/eng_in_valid/eng_clr/eng_out_data/eng_out_valid (engine);
//        res_valid/res_data/res_id/res_err/res_ready (result); busy.
module reduce_arbiter
    import reduce_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = 16,
    parameter int IW        = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       eng_in_data,
    output logic                    eng_in_valid,
    output logic                    eng_clr,
    input  logic [DATA_W-1:0]       eng_out_data,
    input  logic                    eng_out_valid,
    output logic                    res_valid,
    output logic [DATA_W-1:0]       res_data,
    output logic [IW-1:0]           res_id,
    output logic                    res_err,
    input  logic                    res_ready,
    output logic                    busy
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e             state_q;
    logic [IW-1:0]      gnt_q;
    logic [N_REQ-1:0]   gnt_oh_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_d;
    logic [CW-1:0]      cnt_q;
    logic [TW-1:0]      tmr_q;
    logic [DATA_W-1:0]  res_data_q;
    logic               res_err_q;

    logic [N_REQ-1:0]   arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    logic [DATA_W-1:0]  word [N_REQ];
    logic               streaming;
    logic               beat;

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign word[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .gnt_oh_o (arb_oh),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    assign streaming = (state_q == STREAM);
    assign beat      = streaming && |(req_valid & gnt_oh_q);

    assign req_ready    = streaming ? gnt_oh_q : '0;
    assign eng_in_valid = beat;
    assign eng_in_data  = streaming ? word[gnt_q] : '0;

    assign eng_clr   = (state_q == CLEAR);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == RESULT);
    assign res_data  = res_data_q;
    assign res_id    = gnt_q;
    assign res_err   = res_err_q;

    // Pointer moves past the requester just served.
    assign ptr_d = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_oh_q   <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q    <= arb_idx;
                        gnt_oh_q <= arb_oh;
                        cnt_q    <= '0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (cnt_q == CW'(FRAME_LEN - 1)) begin
                            cnt_q   <= '0;
                            tmr_q   <= '0;
                            state_q <= WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (eng_out_valid) begin
                        res_data_q <= eng_out_data;
                        res_err_q  <= 1'b0;
                        state_q    <= RESULT;
                    end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                        // Engine never answered: flag, zero data.
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= RESULT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    ptr_q   <= ptr_d;
                    tmr_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_arbiter.sv
// Randomized bench for reduce_arbiter with a frame-level reference model.
// Includes a behavioural reduce_sum engine model driven by eng_* signals.
module tb_reduce_arbiter;

    localparam int N  = 4;
    localparam int FL = 8;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   eng_in_data;
    logic            eng_in_valid;
    logic            eng_clr;
    logic [DW-1:0]   eng_out_data;
    logic            eng_out_valid;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            res_err;
    logic            res_ready;
    logic            busy;

    always #5 clk = ~clk;

    reduce_arbiter #(
        .N_REQ     (N),
        .FRAME_LEN (FL),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .eng_in_data   (eng_in_data),
        .eng_in_valid  (eng_in_valid),
        .eng_clr       (eng_clr),
        .eng_out_data  (eng_out_data),
        .eng_out_valid (eng_out_valid),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_id        (res_id),
        .res_err       (res_err),
        .res_ready     (res_ready),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester frames
    logic [DW-1:0] words [N][FL];
    logic [DW-1:0] exp_sum [N];
    int            hd [N];
    bit            pend [N];

    // Frame-level scheduler model
    int  ptr, cur, beats, frames, ncnt, last_n, rv_cyc;
    bit  in_frame, hs;
    bit  gap_en, dead;
    int  edelay, hold;
    int  served[$];

    // Engine model
    logic [DW-1:0] esum;
    int            ecnt, elat;
    bit            eov;

    // Result tracking
    bit            prev_rv, prev_rdy, prev_err;
    logic [DW-1:0] prev_d;
    logic [IW-1:0] prev_id;
    logic [DW-1:0] last_d;
    int            last_id;
    bit            last_err;

    task automatic reset_model();
        ptr = 0; cur = 0; beats = 0; in_frame = 0; hs = 0;
        rv_cyc = 0; prev_rv = 0; prev_rdy = 0;
        esum = '0; ecnt = 0; elat = 0; eov = 0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0;
            hd[k] = 0;
        end
    endtask

    task automatic enqueue(input int k, input bit seq);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < FL; i++) begin
            words[k][i] = seq ? DW'(i + 1) : DW'($urandom_range(1, 1 << 20));
            s += words[k][i];
        end
        exp_sum[k] = s;
        hd[k] = 0;
        pend[k] = 1;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                if (in_frame && cur == k && gap_en)
                    req_valid[k] = 1'($urandom_range(0, 1));
                else
                    req_valid[k] = 1'b1;
                req_data[k*DW +: DW] = words[k][hd[k]];
            end else begin
                req_valid[k] = 1'b0;
                req_data[k*DW +: DW] = '0;
            end
        end
        res_ready     = (rv_cyc >= hold);
        eng_out_valid = eov;
        eng_out_data  = esum;
    endtask

    task automatic observe();
        logic [N-1:0] er;
        bit           strm;
        bit           found;
        ncnt++;
        strm = in_frame && (beats < FL);
        er = strm ? N'(1 << cur) : '0;
        chk("req_ready", req_ready, er);
        chk("busy", busy, in_frame);
        chk("eng_in_valid", eng_in_valid, strm ? req_valid[cur] : 1'b0);
        if (strm && eng_in_valid)
            chk("eng_in_data", eng_in_data, words[cur][hd[cur]]);
        chk("eng_clr", eng_clr, hs);
        if (!in_frame)
            chk("res_valid_idle", res_valid, 1'b0);

        if (eng_in_valid) begin
            esum += eng_in_data;
            ecnt++;
        end

        if (hs) begin
            ptr = (cur + 1) % N;
            in_frame = 0;
            hs = 0;
            frames++;
            esum = '0; ecnt = 0; elat = 0; eov = 0;
        end else if (in_frame) begin
            if (req_valid[cur] && req_ready[cur]) begin
                hd[cur]++;
                if (hd[cur] == FL) pend[cur] = 0;
                beats++;
                if (beats == FL) last_n = ncnt;
            end
            if (res_valid) begin
                if (!prev_rv) begin
                    chk("res_id", res_id, cur);
                    chk("res_data", res_data, dead ? '0 : exp_sum[cur]);
                    chk("res_err", res_err, dead);
                    chk("frame_beats", beats, FL);
                    if (dead)
                        chk("timeout_lat", ncnt - last_n, TO + 1);
                    served.push_back(cur);
                    last_d = res_data;
                    last_id = res_id;
                    last_err = res_err;
                end else if (!prev_rdy) begin
                    chk("hold_data", res_data, prev_d);
                    chk("hold_id", res_id, prev_id);
                    chk("hold_err", res_err, prev_err);
                end
                prev_rv = 1;
                prev_rdy = res_ready;
                prev_d = res_data;
                prev_id = res_id;
                prev_err = res_err;
                rv_cyc++;
                if (res_ready) begin
                    hs = 1;
                    rv_cyc = 0;
                    prev_rv = 0;
                end
            end
        end else if (req_valid != '0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (ptr + i) % N;
                if (!found && req_valid[k]) begin
                    found = 1;
                    cur = k;
                end
            end
            in_frame = 1;
            beats = 0;
        end

        if (ecnt >= FL && !dead && !eov) begin
            if (elat >= edelay) eov = 1;
            else elat++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic run_frames(input int n);
        int target;
        int cyc;
        target = frames + n;
        cyc = 0;
        while (frames < target && cyc < 200 * n) begin
            tick();
            cyc++;
        end
        if (frames < target)
            chk("frame_budget", frames, target);
    endtask

    initial begin
        int exp_ord [7];
        int mask, cnt;
        exp_ord = '{0, 1, 3, 0, 1, 2, 3};
        rst = 1'b1;
        req_valid = '0; req_data = '0; res_ready = 1'b0;
        eng_out_valid = 1'b0; eng_out_data = '0;
        frames = 0; ncnt = 0; last_n = 0;
        hold = 0; dead = 0; gap_en = 0; edelay = 1;
        reset_model();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_eng_clr", eng_clr, 1'b0);
        chk("rst_res_data", res_data, '0);
        chk("rst_res_err", res_err, 1'b0);
        rst = 1'b0;

        // Words 1..8 from requester 0
        enqueue(0, 1);
        run_frames(1);
        chk("t1_sum", last_d, 36);
        chk("t1_id", last_id, 0);

        // Round-robin order
        enqueue(1, 0);
        enqueue(3, 0);
        run_frames(2);
        for (int k = 0; k < N; k++) enqueue(k, 0);
        run_frames(4);
        chk("order_len", served.size(), 7);
        for (int i = 0; i < 7 && i < served.size(); i++)
            chk("order", served[i], exp_ord[i]);

        // Gappy streams, random engine latency
        gap_en = 1;
        repeat (4) begin
            mask = $urandom_range(1, 15);
            edelay = $urandom_range(0, 3);
            cnt = 0;
            for (int k = 0; k < N; k++)
                if (mask[k]) begin
                    enqueue(k, 0);
                    cnt++;
                end
            run_frames(cnt);
        end
        gap_en = 0;

        // Engine never answers
        dead = 1;
        enqueue(1, 0);
        run_frames(1);
        chk("t4_err", last_err, 1'b1);
        chk("t4_data", last_d, '0);
        dead = 0;

        // Consumer stalls for 10 cycles
        hold = 10;
        enqueue(0, 0);
        enqueue(2, 0);
        run_frames(2);
        hold = 0;

        // Reset in the middle of a frame
        enqueue(0, 0);
        cnt = 0;
        while (beats < 5 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t6_beats", beats >= 5, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_req_ready", req_ready, '0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_eng_in_valid", eng_in_valid, 1'b0);
        chk("mid_eng_clr", eng_clr, 1'b0);
        chk("mid_res_valid", res_valid, 1'b0);
        chk("mid_res_err", res_err, 1'b0);
        chk("mid_res_data", res_data, '0);
        reset_model();
        req_valid = '0;
        eng_out_valid = 1'b0;
        eng_out_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        enqueue(2, 0);
        run_frames(1);
        chk("t6_id", last_id, 2);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduce_arbiter.md
# reduce_arbiter

Frame-level scheduler that shares one reduce_sum engine among N_REQ streaming requesters. It grants the engine to one requester at a time in round-robin order and forwards exactly FRAME_LEN words from that requester into the engine. It then waits for the engine's result, returns it tagged with the requester id, and clears the engine before the next frame. It sits between the requester-side stream muxing and the reduction datapath.

## Interface
- N_REQ, 4, number of requesters (≥2)
- FRAME_LEN, 2048, words per frame; must equal the engine's BUFFER_DEPTH
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles to wait for eng_out_valid after the last word
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*DATA_W  per-requester word, requester k at bits [k*DATA_W +: DATA_W]
- req_ready  out  N_REQ  per-requester word accept
- eng_in_data  out  DATA_W  word to engine
- eng_in_valid  out  1  word strobe to engine
- eng_clr  out  1  one-cycle engine clear, OR'd with rst at the engine's reset input
- eng_out_data  in  DATA_W  engine result
- eng_out_valid  in  1  engine result valid; level, sticky until cleared
- res_valid  out  1  result available
- res_data  out  DATA_W  captured result
- res_id  out  $clog2(N_REQ)  requester that owns the result
- res_err  out  1  result produced by timeout, data invalid
- res_ready  in  1  result consumer accept
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE → STREAM → WAIT → RESULT → CLEAR → IDLE.
- IDLE:
  - If any req_valid is high, the round-robin arbiter picks the first requester at or after rr_ptr. That requester is registered into gnt and the FSM moves to STREAM.
  - After reset, rr_ptr = 0.
- STREAM:
  - req_ready[gnt] = 1; all other req_ready bits are 0.
  - eng_in_valid = req_valid[gnt]; eng_in_data = req_data[gnt]. Both are combinational.
  - Beat counter cnt (width $clog2(FRAME_LEN+1)) increments on each accepted beat.
  - On the FRAME_LEN-th beat: go to WAIT, cnt ← 0.
  - Gaps in req_valid stall the frame and never abort it.
- WAIT:
  - eng_in_valid = 0.
  - If eng_out_valid = 1: res_data ← eng_out_data, res_err ← 0, go to RESULT.
  - Otherwise the timer increments. When it reaches TIMEOUT: res_data ← 0, res_err ← 1, go to RESULT.
- RESULT:
  - res_valid = 1 and res_id = gnt. res_data, res_id and res_err are held stable.
  - On res_valid & res_ready: go to CLEAR.
- CLEAR:
  - eng_clr = 1 for exactly one cycle.
  - rr_ptr ← gnt+1 (mod N_REQ).
  - Go to IDLE.
- The grant is locked for the whole frame. Requests from other requesters during STREAM, WAIT, RESULT or CLEAR are ignored and never lost; their req_valid stays high.
- Reset (any time, including mid-frame):
  - State → IDLE; cnt, timer, gnt and rr_ptr → 0.
  - res_valid, res_err, eng_in_valid, eng_clr, busy, req_ready → 0; res_data → 0.
  - The engine is reset through the shared rst. A partial frame is discarded.

## Timing
- Grant latency: req_valid seen in IDLE at cycle t → req_ready high at cycle t+1.
- Throughput: one word per cycle in STREAM.
- Minimum frame occupancy: 1 (IDLE) + FRAME_LEN + WAIT + ≥1 (RESULT) + 1 (CLEAR) cycles.
- WAIT takes 1 cycle if eng_out_valid is already high on entry. Otherwise it exits on the cycle eng_out_valid is first sampled high, or after TIMEOUT cycles.
- res_valid rises the cycle after the WAIT exit condition.
- eng_clr is high in the cycle after the res handshake.
- The next IDLE grant can occur 1 cycle after CLEAR.
- res_ready held high in RESULT completes the handshake in that same cycle.

## Structure
- Shared package reduce_pkg holds:
  - the state enum (IDLE, STREAM, WAIT, RESULT, CLEAR), 3-bit;
  - the id-width helper function;
  - the default DATA_W and FRAME_LEN constants, also used by reduce_sum instantiations.
- One sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Instantiated once; the grant register lives in reduce_arbiter.

## Test plan
- Single requester 0, FRAME_LEN=8, words 1..8, engine model returns 36 → res_valid with res_data=36, res_id=0, res_err=0. eng_clr pulses once after res_ready.
- Requesters 1 and 3 both valid from reset → frames served in order 1, 3. Then, with all four valid, the order continues 0, 1, 2, 3.
- req_valid toggled 50% during STREAM → exactly 8 eng_in_valid beats; req_ready never high for non-granted requesters.
- Engine model never asserts eng_out_valid, TIMEOUT=16 → res_valid 17 cycles after the last beat, res_err=1, res_data=0.
- res_ready held low for 10 cycles → res_* stable for all 10 cycles; no new grant until after CLEAR.
- rst asserted after 5 of 8 beats → all outputs 0 immediately. A following full frame from requester 2 returns the correct sum with res_id=2.
